// File: rtl/video_pattern_gen.sv
// AXI4-Stream test-pattern video source: framed DW-bit pixel beats with tuser/tlast,
// backpressure-safe, with a programmable idle gap between frames.
module video_pattern_gen #(
    parameter int DW           = 16,
    parameter int H_ACTIVE     = 64,
    parameter int V_ACTIVE     = 48,
    parameter int BLANK_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [2:0]    pattern,
    output logic [DW-1:0] v_m_tdata,
    output logic          v_m_tvalid,
    input  logic          v_m_tready,
    output logic          v_m_tlast,
    output logic          v_m_tuser,
    output logic [15:0]   frame_count,
    output logic          busy,
    output logic          frame_done
);

    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int YW = $clog2(V_ACTIVE + 1);
    localparam int BW = $clog2(BLANK_CYCLES + 2);

    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
    localparam logic [XW-1:0] X_ONE  = XW'(1'b1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1'b1);
    localparam logic [BW-1:0] B_ONE  = BW'(1'b1);
    localparam logic [BW-1:0] B_LAST = (BLANK_CYCLES > 0) ? BW'(BLANK_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_BLANK  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [BW-1:0] blank_q, blank_d;
    logic [2:0]    pattern_q, pattern_d;
    logic [DW-1:0] tdata_q, tdata_d;
    logic          tvalid_q, tvalid_d;
    logic          tlast_q, tlast_d;
    logic          tuser_q, tuser_d;
    logic [15:0]   frame_count_q, frame_count_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;

    logic          launch_s;
    logic          advance_s;
    logic          frame_end_s;

    function automatic logic [DW-1:0] pixel(
        input logic [2:0]    p,
        input logic [XW-1:0] x,
        input logic [YW-1:0] y,
        input logic [15:0]   fc
    );
        logic [DW-1:0] r;
        logic [31:0]   sh;
        r  = '0;
        sh = 32'(x) % 32'(DW);
        case (p)
            3'd0:    r = {DW{1'b1}};
            3'd1:    r = {DW{x[0] ^ y[0]}};
            3'd2:    r = DW'(x);
            3'd3:    r = DW'(y);
            3'd4:    r = {{(DW-1){1'b0}}, 1'b1} << sh;
            3'd5:    r = DW'(fc);
            default: r = '0;
        endcase
        return r;
    endfunction

    // Sequencing: frame start, beat advance, frame end, blanking and the next-beat outputs
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        blank_d       = blank_q;
        pattern_d     = pattern_q;
        tdata_d       = tdata_q;
        tvalid_d      = tvalid_q;
        tlast_d       = tlast_q;
        tuser_d       = tuser_q;
        frame_count_d = frame_count_q;
        frame_done_d  = 1'b0;
        launch_s      = 1'b0;
        advance_s     = 1'b0;
        frame_end_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                launch_s = en;
            end
            ST_ACTIVE: begin
                if (tvalid_q && v_m_tready) begin
                    if ((x_q == X_LAST) && (y_q == Y_LAST)) begin
                        frame_end_s = 1'b1;
                    end else begin
                        advance_s = 1'b1;
                    end
                end else begin
                    advance_s = 1'b0;
                end
            end
            ST_BLANK: begin
                if (blank_q == B_LAST) begin
                    state_d  = ST_IDLE;
                    launch_s = en;
                end else begin
                    blank_d = blank_q + B_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (frame_end_s) begin
            frame_done_d  = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
            x_d           = '0;
            y_d           = '0;
            blank_d       = '0;
            tvalid_d      = 1'b0;
            tlast_d       = 1'b0;
            tuser_d       = 1'b0;
            // With no blanking the en check happens on the same edge as the last beat
            if (BLANK_CYCLES == 0) begin
                state_d  = ST_IDLE;
                launch_s = en;
            end else begin
                state_d = ST_BLANK;
            end
        end else begin
            frame_done_d = 1'b0;
        end

        if (advance_s) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = y_q + Y_ONE;
            end else begin
                x_d = x_q + X_ONE;
            end
        end else begin
            x_d = x_d;
        end

        if (launch_s) begin
            state_d   = ST_ACTIVE;
            pattern_d = pattern;
            x_d       = '0;
            y_d       = '0;
        end else begin
            pattern_d = pattern_d;
        end

        // frame_count_d already carries the increment when a frame starts back-to-back
        if (launch_s || advance_s) begin
            tvalid_d = 1'b1;
            tuser_d  = (x_d == '0) && (y_d == '0);
            tlast_d  = (x_d == X_LAST);
            tdata_d  = pixel(pattern_d, x_d, y_d, frame_count_d);
        end else begin
            tdata_d = tdata_d;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            blank_q       <= '0;
            pattern_q     <= 3'd0;
            tdata_q       <= '0;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            tuser_q       <= 1'b0;
            frame_count_q <= 16'd0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            blank_q       <= blank_d;
            pattern_q     <= pattern_d;
            tdata_q       <= tdata_d;
            tvalid_q      <= tvalid_d;
            tlast_q       <= tlast_d;
            tuser_q       <= tuser_d;
            frame_count_q <= frame_count_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign v_m_tdata   = tdata_q;
    assign v_m_tvalid  = tvalid_q;
    assign v_m_tlast   = tlast_q;
    assign v_m_tuser   = tuser_q;
    assign frame_count = frame_count_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Scoreboard bench for video_pattern_gen: three instances (4x2 blank 4, 20x2 blank 0,
// 1x1 blank 0) with expected beats queued at stimulus time and popped on acceptance.
module tb_video_pattern_gen;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
        logic        u;
        logic        eof;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s   [3];
    logic        en_s    [3];
    logic [2:0]  pat_s   [3];
    logic        rdy_s   [3];
    logic [15:0] data_s  [3];
    logic        valid_s [3];
    logic        last_s  [3];
    logic        user_s  [3];
    logic        busy_s  [3];
    logic        done_s  [3];
    logic [15:0] fc_s    [3];

    beat_t sb [3][$];
    int acc_cnt [3] = '{0, 0, 0};
    int h_of    [3] = '{4, 20, 1};
    int v_of    [3] = '{2, 2, 1};
    int n_checks = 0;
    int n_errors = 0;

    video_pattern_gen #(.DW(16), .H_ACTIVE(4), .V_ACTIVE(2), .BLANK_CYCLES(4)) u_dut_a (
        .clk(clk), .rst(rst_s[0]), .en(en_s[0]), .pattern(pat_s[0]),
        .v_m_tdata(data_s[0]), .v_m_tvalid(valid_s[0]), .v_m_tready(rdy_s[0]),
        .v_m_tlast(last_s[0]), .v_m_tuser(user_s[0]), .frame_count(fc_s[0]),
        .busy(busy_s[0]), .frame_done(done_s[0]));

    video_pattern_gen #(.DW(16), .H_ACTIVE(20), .V_ACTIVE(2), .BLANK_CYCLES(0)) u_dut_b (
        .clk(clk), .rst(rst_s[1]), .en(en_s[1]), .pattern(pat_s[1]),
        .v_m_tdata(data_s[1]), .v_m_tvalid(valid_s[1]), .v_m_tready(rdy_s[1]),
        .v_m_tlast(last_s[1]), .v_m_tuser(user_s[1]), .frame_count(fc_s[1]),
        .busy(busy_s[1]), .frame_done(done_s[1]));

    video_pattern_gen #(.DW(16), .H_ACTIVE(1), .V_ACTIVE(1), .BLANK_CYCLES(0)) u_dut_c (
        .clk(clk), .rst(rst_s[2]), .en(en_s[2]), .pattern(pat_s[2]),
        .v_m_tdata(data_s[2]), .v_m_tvalid(valid_s[2]), .v_m_tready(rdy_s[2]),
        .v_m_tlast(last_s[2]), .v_m_tuser(user_s[2]), .frame_count(fc_s[2]),
        .busy(busy_s[2]), .frame_done(done_s[2]));

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_pix(input int p, input int x, input int y, input logic [15:0] f);
        logic [15:0] r;
        int          sh;
        sh = x % 16;
        case (p)
            0:       r = 16'hFFFF;
            1:       r = (((x ^ y) & 1) != 0) ? 16'hFFFF : 16'h0000;
            2:       r = 16'(x);
            3:       r = 16'(y);
            4:       r = 16'd1 << sh;
            5:       r = f;
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    task automatic push_frame(input int i, input int p, input logic [15:0] f);
        beat_t b;
        for (int y = 0; y < v_of[i]; y++) begin
            for (int x = 0; x < h_of[i]; x++) begin
                b.d   = exp_pix(p, x, y, f);
                b.l   = (x == h_of[i] - 1);
                b.u   = (x == 0) && (y == 0);
                b.eof = (x == h_of[i] - 1) && (y == v_of[i] - 1);
                sb[i].push_back(b);
            end
        end
    endtask

    task automatic wait_done(input int i, input int max);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done_s[i] && n < max);
        if (!done_s[i]) check_val($sformatf("timeout_done[%0d]", i), 32'd0, 32'd1);
    endtask

    task automatic wait_fc(input int i, input logic [15:0] val, input int max);
        int n;
        n = 0;
        while (fc_s[i] !== val && n < max) begin
            @(posedge clk); #1;
            n++;
        end
        if (fc_s[i] !== val) check_val($sformatf("timeout_fc[%0d]", i), 32'(fc_s[i]), 32'(val));
    endtask

    // Per-instance monitor: pops on acceptance, checks stalls, frame_done, count and gap
    for (genvar gi = 0; gi < 3; gi++) begin : g_mon
        localparam int BLANK = (gi == 0) ? 4 : 0;
        initial begin
            logic        stall, done_exp, gap_arm;
            logic [15:0] st_d, exp_fc;
            logic        st_l, st_u;
            int          gap;
            beat_t       b;
            stall = 1'b0; done_exp = 1'b0; gap_arm = 1'b0; exp_fc = 16'd0; gap = 0;
            st_d = 16'd0; st_l = 1'b0; st_u = 1'b0;
            forever begin
                @(negedge clk);
                if (rst_s[gi]) begin
                    sb[gi].delete();
                    stall = 1'b0; done_exp = 1'b0; gap_arm = 1'b0; exp_fc = 16'd0; gap = 0;
                end else begin
                    if (done_exp || done_s[gi])
                        check_val($sformatf("frame_done[%0d]", gi), 32'(done_s[gi]), 32'(done_exp));
                    if (done_exp)
                        check_val($sformatf("frame_count[%0d]", gi), 32'(fc_s[gi]), 32'(exp_fc));
                    done_exp = 1'b0;
                    if (stall) begin
                        check_val($sformatf("stall_valid[%0d]", gi), 32'(valid_s[gi]), 32'd1);
                        check_val($sformatf("stall_data[%0d]", gi), 32'(data_s[gi]), 32'(st_d));
                        check_val($sformatf("stall_last[%0d]", gi), 32'(last_s[gi]), 32'(st_l));
                        check_val($sformatf("stall_user[%0d]", gi), 32'(user_s[gi]), 32'(st_u));
                    end
                    stall = 1'b0;
                    if (valid_s[gi]) begin
                        if (gap_arm) begin
                            check_val($sformatf("blank_gap[%0d]", gi), 32'(gap), 32'(BLANK));
                            gap_arm = 1'b0;
                        end
                        if (rdy_s[gi]) begin
                            check_val($sformatf("beat_expected[%0d]", gi), 32'(sb[gi].size() != 0), 32'd1);
                            if (sb[gi].size() != 0) begin
                                b = sb[gi].pop_front();
                                check_val($sformatf("tdata[%0d]", gi), 32'(data_s[gi]), 32'(b.d));
                                check_val($sformatf("tlast[%0d]", gi), 32'(last_s[gi]), 32'(b.l));
                                check_val($sformatf("tuser[%0d]", gi), 32'(user_s[gi]), 32'(b.u));
                                acc_cnt[gi]++;
                                if (b.eof) begin
                                    done_exp = 1'b1;
                                    exp_fc   = exp_fc + 16'd1;
                                    gap_arm  = en_s[gi];
                                    gap      = 0;
                                end
                            end
                        end else begin
                            stall = 1'b1;
                            st_d  = data_s[gi];
                            st_l  = last_s[gi];
                            st_u  = user_s[gi];
                        end
                    end else begin
                        gap++;
                    end
                end
            end
        end
    end

    initial begin
        int base;
        for (int i = 0; i < 3; i++) begin
            rst_s[i] = 1'b1; en_s[i] = 1'b0; pat_s[i] = 3'd0; rdy_s[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_valid", 32'(valid_s[0]), 32'd0);
        check_val("rst_data", 32'(data_s[0]), 32'd0);
        check_val("rst_fc", 32'(fc_s[0]), 32'd0);
        check_val("rst_busy", 32'(busy_s[0]), 32'd0);
        check_val("rst_done", 32'(done_s[0]), 32'd0);
        check_val("rst_user_last", 32'({user_s[0], last_s[0]}), 32'd0);
        for (int i = 0; i < 3; i++) rst_s[i] = 1'b0;

        // A: solid frame, latency, then pattern 2 with stalls and en dropped mid-frame
        en_s[0] = 1'b1; pat_s[0] = 3'd0;
        push_frame(0, 0, 16'd0);
        @(posedge clk); #1;
        check_val("latency_valid", 32'(valid_s[0]), 32'd1);
        check_val("latency_user", 32'(user_s[0]), 32'd1);
        check_val("latency_busy", 32'(busy_s[0]), 32'd1);
        pat_s[0] = 3'd2;
        push_frame(0, 2, 16'd1);
        wait_done(0, 40);
        for (int c = 0; c < 200; c++) begin
            rdy_s[0] = ((c % 4) == 0) || ((c % 4) == 3);
            if (c == 6) en_s[0] = 1'b0;
            @(posedge clk); #1;
            if (done_s[0]) break;
        end
        rdy_s[0] = 1'b1;
        check_val("drop_done", 32'(done_s[0]), 32'd1);
        for (int k = 0; k < 4; k++) begin
            check_val("drop_busy_high", 32'(busy_s[0]), 32'd1);
            check_val("drop_blank_valid", 32'(valid_s[0]), 32'd0);
            @(posedge clk); #1;
        end
        check_val("drop_busy_low", 32'(busy_s[0]), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_val("idle_valid", 32'(valid_s[0]), 32'd0);

        // A: async reset at x=2,y=1, then a clean restart
        en_s[0] = 1'b1; pat_s[0] = 3'd3;
        base = acc_cnt[0];
        push_frame(0, 3, 16'd2);
        for (int n = 0; n < 30 && acc_cnt[0] < base + 6; n++) begin
            @(posedge clk); #1;
        end
        check_val("reach_x2y1", 32'(acc_cnt[0] - base), 32'd6);
        #2 rst_s[0] = 1'b1;
        #1;
        check_val("async_valid", 32'(valid_s[0]), 32'd0);
        check_val("async_busy", 32'(busy_s[0]), 32'd0);
        check_val("async_fc", 32'(fc_s[0]), 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_s[0] = 1'b0; pat_s[0] = 3'd1;
        push_frame(0, 1, 16'd0);
        @(posedge clk); #1;
        check_val("restart_user", 32'(user_s[0]), 32'd1);
        check_val("restart_fc", 32'(fc_s[0]), 32'd0);
        en_s[0] = 1'b0;
        wait_done(0, 40);
        repeat (6) @(posedge clk);
        #1;
        check_val("restart_idle", 32'(busy_s[0]), 32'd0);

        // B: walking one over 20 beats, pattern switched mid-frame, back-to-back frames
        en_s[1] = 1'b1; pat_s[1] = 3'd4;
        push_frame(1, 4, 16'd0);
        repeat (4) @(posedge clk);
        #1;
        pat_s[1] = 3'd1;
        push_frame(1, 1, 16'd1);
        wait_fc(1, 16'd1, 100);
        en_s[1] = 1'b0;
        wait_done(1, 100);
        repeat (3) @(posedge clk);
        #1;
        check_val("b_idle_valid", 32'(valid_s[1]), 32'd0);
        check_val("b_fc", 32'(fc_s[1]), 32'd2);

        // C: 1x1 frames until frame_count wraps, then FCOUNT shows zero
        en_s[2] = 1'b1; pat_s[2] = 3'd0;
        for (int k = 0; k < 65536; k++) push_frame(2, 0, 16'(k));
        wait_fc(2, 16'hFFFF, 70000);
        pat_s[2] = 3'd5;
        push_frame(2, 5, 16'd0);
        wait_fc(2, 16'h0000, 5);
        check_val("c_wrap_fc", 32'(fc_s[2]), 32'd0);
        en_s[2] = 1'b0;
        wait_done(2, 5);
        repeat (3) @(posedge clk);
        #1;
        check_val("c_idle_valid", 32'(valid_s[2]), 32'd0);
        check_val("c_final_fc", 32'(fc_s[2]), 32'd1);

        for (int i = 0; i < 3; i++)
            check_val($sformatf("sb_drained[%0d]", i), 32'(sb[i].size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
